// File: rtl/n1_prog_loader.sv
// Program loader for the n1 core: framed byte stream -> 16-bit instruction RAM writes.
// Optional inter-byte timeout is compiled in with `define LOADER_TIMEOUT_EN.
module n1_prog_loader #(
  parameter int         RAM_WORDS      = 128,
  parameter int         ADDR_BITS      = $clog2(RAM_WORDS),
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_byte_in,
  input  logic                 i_byte_valid,
  output logic                 o_byte_ready,
  output logic                 o_mem_we,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [15:0]          o_mem_wdata,
  output logic                 o_cpu_hold,
  output logic                 o_done,
  output logic                 o_error,
  output logic [7:0]           o_words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [8:0] MAX_WORDS = 9'(RAM_WORDS);

  // The word counter is 8 bits wide, so the RAM may not exceed 255 words.
  if (RAM_WORDS < 1 || RAM_WORDS > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("n1_prog_loader: RAM_WORDS must be 1..255 and TIMEOUT_CYCLES >= 2");
  end

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_count;
  logic [7:0]  r_checksum;
  logic [7:0]  r_hiByte;
  logic [7:0]  r_wordsLoaded;
  logic [15:0] r_wdata;
  logic        r_cpuHold;
  logic        r_done;
  logic        r_error;

  logic        w_accept;
  logic        w_isSync;
  logic        w_tooBig;
  logic [7:0]  w_wordsNext;
  logic        w_timeout;

  assign o_byte_ready   = (r_state != S_WRITE);
  assign w_accept       = i_byte_valid && o_byte_ready;
  assign w_isSync       = (i_byte_in == SYNC_BYTE);
  assign w_tooBig       = ({1'b0, i_byte_in} > MAX_WORDS);
  assign w_wordsNext    = r_wordsLoaded + 8'd1;

  assign o_mem_we       = (r_state == S_WRITE);
  assign o_mem_addr     = r_wordsLoaded[ADDR_BITS-1:0];
  assign o_mem_wdata    = r_wdata;
  assign o_cpu_hold     = r_cpuHold;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_wordsLoaded;

`ifdef LOADER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_idleCnt;
  logic        w_waiting;

  assign w_waiting = (r_state == S_COUNT) || (r_state == S_HI) ||
                     (r_state == S_LO)    || (r_state == S_CHK);
  assign w_timeout = w_waiting && !w_accept && (r_idleCnt == TIMEOUT_LAST);

  // Idle counter only runs while a frame is waiting for its next byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idleCnt <= 16'd0;
    end else if (w_waiting && !w_accept && !w_timeout) begin
      r_idleCnt <= r_idleCnt + 16'd1;
    end else begin
      r_idleCnt <= 16'd0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_accept && w_isSync) begin
          w_nextState = S_COUNT;
        end
      end
      S_COUNT: begin
        if (w_accept) begin
          if (w_tooBig) begin
            w_nextState = S_ERR;
          end else if (i_byte_in == 8'd0) begin
            w_nextState = S_CHK;
          end else begin
            w_nextState = S_HI;
          end
        end
      end
      S_HI: begin
        if (w_accept) begin
          w_nextState = S_LO;
        end
      end
      S_LO: begin
        if (w_accept) begin
          w_nextState = S_WRITE;
        end
      end
      S_WRITE: begin
        w_nextState = (w_wordsNext == r_count) ? S_CHK : S_HI;
      end
      S_CHK: begin
        if (w_accept) begin
          w_nextState = (i_byte_in == r_checksum) ? S_DONE : S_ERR;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
    if (w_timeout) begin
      w_nextState = S_ERR;
    end
  end

  // Status flags are registered from the next state so they change on the
  // same edge that moves the FSM, including the reload on a sync byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cpuHold <= 1'b1;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_cpuHold <= (w_nextState != S_DONE);
      r_done    <= (w_nextState == S_DONE);
      r_error   <= (w_nextState == S_ERR);
    end
  end

  // The high byte is parked separately so mem_wdata only moves on a low byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count       <= 8'd0;
      r_checksum    <= 8'd0;
      r_hiByte      <= 8'd0;
      r_wordsLoaded <= 8'd0;
      r_wdata       <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_accept && w_isSync) begin
            r_checksum    <= 8'd0;
            r_wordsLoaded <= 8'd0;
          end
        end
        S_COUNT: begin
          if (w_accept) begin
            r_count    <= i_byte_in;
            r_checksum <= r_checksum ^ i_byte_in;
          end
        end
        S_HI: begin
          if (w_accept) begin
            r_hiByte   <= i_byte_in;
            r_checksum <= r_checksum ^ i_byte_in;
          end
        end
        S_LO: begin
          if (w_accept) begin
            r_wdata    <= {r_hiByte, i_byte_in};
            r_checksum <= r_checksum ^ i_byte_in;
          end
        end
        S_WRITE: begin
          r_wordsLoaded <= w_wordsNext;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n1_prog_loader.sv
// Self-checking bench for n1_prog_loader: directed frames plus random frames
// checked against a frame-level reference model.
module tb_n1_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        memWe;
  logic [6:0]  memAddr;
  logic [15:0] memWdata;
  logic        cpuHold;
  logic        done;
  logic        error;
  logic [7:0]  wordsLoaded;

  int total = 0;
  int bad   = 0;

  logic [22:0] writes[$];
  logic [22:0] expWrites[$];
  logic [7:0]  stream[$];
  logic        expDone;
  logic        expErr;
  logic [7:0]  expWl;

  n1_prog_loader dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_byte_in      (byteIn),
    .i_byte_valid   (byteValid),
    .o_byte_ready   (byteReady),
    .o_mem_we       (memWe),
    .o_mem_addr     (memAddr),
    .o_mem_wdata    (memWdata),
    .o_cpu_hold     (cpuHold),
    .o_done         (done),
    .o_error        (error),
    .o_words_loaded (wordsLoaded)
  );

  always #5 clk = ~clk;

  // Record every RAM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (memWe === 1'b1) writes.push_back({memAddr, memWdata});
  end

  task automatic sendByte(input logic [7:0] b);
    int waitCycles;
    @(negedge clk);
    byteIn = b;
    byteValid = 1'b1;
    waitCycles = 0;
    while (byteReady !== 1'b1 && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    total++;
    if (byteReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL handshake byte=%02h ready=%b required=1", b, byteReady);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic endStream();
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  task automatic sendStream();
    foreach (stream[i]) sendByte(stream[i]);
    endStream();
  endtask

  // Frame-level reference: skip junk, find sync, then interpret N, payload, CHK.
  task automatic modelStream();
    int idx;
    int n;
    logic [7:0] x;
    expWrites.delete();
    expWl = 8'd0;
    idx = 0;
    while (idx < stream.size() && stream[idx] != 8'hA5) idx++;
    idx++;
    n = int'(stream[idx]);
    idx++;
    if (n > 128) begin
      expDone = 1'b0;
      expErr  = 1'b1;
      return;
    end
    x = 8'(n);
    for (int i = 0; i < n; i++) begin
      x = x ^ stream[idx] ^ stream[idx+1];
      expWrites.push_back({7'(i), stream[idx], stream[idx+1]});
      idx += 2;
    end
    expWl   = 8'(n);
    expDone = (stream[idx] == x);
    expErr  = !expDone;
  endtask

  task automatic buildFrame(input int n, input bit corrupt, input int junk);
    logic [7:0] x;
    logic [7:0] b;
    stream.delete();
    for (int i = 0; i < junk; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      stream.push_back(b);
    end
    stream.push_back(8'hA5);
    stream.push_back(8'(n));
    if (n > 128) return;
    x = 8'(n);
    for (int i = 0; i < 2 * n; i++) begin
      b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
      stream.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ (8'd1 << $urandom_range(0, 7));
    stream.push_back(x);
  endtask

  task automatic test_reset();
    total++;
    if ({byteReady, memWe, memAddr, memWdata, cpuHold, done, error, wordsLoaded} !==
        {1'b1, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("[TB] FAIL reset_values got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b wl=%0d",
               byteReady, memWe, memAddr, memWdata, cpuHold, done, error, wordsLoaded);
    end
  endtask

  task automatic test_basic_frame();
    writes.delete();
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h10);
    total++;
    if (memWe !== 1'b0) begin bad++; $display("[TB] FAIL early_we got=%b required=0", memWe); end
    sendByte(8'h2A);
    total++;
    if ({memWe, memAddr, memWdata} !== {1'b1, 7'd0, 16'h102A}) begin
      bad++; $display("[TB] FAIL write0 got we=%b a=%h d=%h required 1/0/102A", memWe, memAddr, memWdata);
    end
    sendByte(8'h40); sendByte(8'h2A);
    total++;
    if ({memWe, memAddr, memWdata} !== {1'b1, 7'd1, 16'h402A}) begin
      bad++; $display("[TB] FAIL write1 got we=%b a=%h d=%h required 1/1/402A", memWe, memAddr, memWdata);
    end
    sendByte(8'h52);
    total++;
    if ({done, error, cpuHold, wordsLoaded} !== {1'b1, 1'b0, 1'b0, 8'd2}) begin
      bad++; $display("[TB] FAIL basic_done got done=%b err=%b hold=%b wl=%0d required 1/0/0/2", done, error, cpuHold, wordsLoaded);
    end
    endStream();
    total++;
    if (writes.size() != 2) begin bad++; $display("[TB] FAIL basic_write_count got=%0d required=2", writes.size()); end
  endtask

  task automatic test_bad_checksum();
    writes.delete();
    stream = '{8'hA5, 8'h02, 8'h10, 8'h2A, 8'h40, 8'h2A, 8'h53};
    sendStream();
    total++;
    if ({done, error, cpuHold} !== 3'b011) begin
      bad++; $display("[TB] FAIL badchk_flags got done=%b err=%b hold=%b required 0/1/1", done, error, cpuHold);
    end
    total++;
    if (writes.size() != 2 || writes[0] !== {7'd0, 16'h102A} || writes[1] !== {7'd1, 16'h402A}) begin
      bad++; $display("[TB] FAIL badchk_writes got count=%0d required 2 writes 102A,402A", writes.size());
    end
  endtask

  task automatic test_zero_frame();
    writes.delete();
    stream = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    foreach (stream[i]) sendByte(stream[i]);
    total++;
    if ({done, error, cpuHold, wordsLoaded} !== {1'b1, 1'b0, 1'b0, 8'd0} || writes.size() != 0) begin
      bad++; $display("[TB] FAIL zero_frame got done=%b err=%b hold=%b wl=%0d writes=%0d required 1/0/0/0/0",
                      done, error, cpuHold, wordsLoaded, writes.size());
    end
    sendByte(8'hA5);
    total++;
    if ({done, cpuHold} !== 2'b01) begin
      bad++; $display("[TB] FAIL reload_hold got done=%b hold=%b required 0/1", done, cpuHold);
    end
    sendByte(8'h00); sendByte(8'h00);
    endStream();
    total++;
    if (done !== 1'b1) begin bad++; $display("[TB] FAIL reload_done got=%b required=1", done); end
  endtask

  task automatic test_oversize();
    writes.delete();
    sendByte(8'hA5); sendByte(8'h81);
    total++;
    if ({done, error, cpuHold} !== 3'b011) begin
      bad++; $display("[TB] FAIL oversize_flags got done=%b err=%b hold=%b required 0/1/1", done, error, cpuHold);
    end
    endStream();
    repeat (3) @(negedge clk);
    total++;
    if (writes.size() != 0) begin bad++; $display("[TB] FAIL oversize_writes got=%0d required=0", writes.size()); end
    stream = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27};
    sendStream();
    total++;
    if (done !== 1'b1 || error !== 1'b0 || writes.size() != 1 || writes[0] !== {7'd0, 16'h1234}) begin
      bad++; $display("[TB] FAIL after_oversize got done=%b err=%b writes=%0d required done, one write 1234",
                      done, error, writes.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    writes.delete();
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h11);
    @(negedge clk);
    byteValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    sendByte(8'h34);
    endStream();
    repeat (4) @(negedge clk);
    total++;
    if (writes.size() != 0 || wordsLoaded !== 8'd0 || cpuHold !== 1'b1 || done !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_abort got writes=%0d wl=%0d hold=%b done=%b required 0/0/1/0",
                      writes.size(), wordsLoaded, cpuHold, done);
    end
  endtask

  task automatic test_idle_wait();
    int cycles;
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'h12);
    endStream();
`ifdef LOADER_TIMEOUT_EN
    cycles = 0;
    while (error !== 1'b1 && cycles < 1100) begin
      @(negedge clk);
      cycles++;
    end
    total++;
    if (error !== 1'b1 || cycles < 1000 || cycles > 1030) begin
      bad++; $display("[TB] FAIL timeout got err=%b after %0d cycles required err=1 near 1024", error, cycles);
    end
`else
    cycles = 0;
    repeat (1100) begin
      @(negedge clk);
      cycles++;
    end
    total++;
    if ({error, done, cpuHold} !== 3'b001) begin
      bad++; $display("[TB] FAIL no_timeout got err=%b done=%b hold=%b after %0d cycles required 0/0/1",
                      error, done, cpuHold, cycles);
    end
    sendByte(8'h34); sendByte(8'h27);
    endStream();
    total++;
    if (done !== 1'b1) begin bad++; $display("[TB] FAIL late_finish got done=%b required=1", done); end
`endif
  endtask

  task automatic test_max_frame();
    writes.delete();
    buildFrame(128, 1'b0, 0);
    modelStream();
    sendStream();
    total++;
    if (done !== expDone || wordsLoaded !== expWl || writes.size() != expWrites.size()) begin
      bad++; $display("[TB] FAIL max_frame got done=%b wl=%0d writes=%0d required %b/%0d/%0d",
                      done, wordsLoaded, writes.size(), expDone, expWl, expWrites.size());
    end else begin
      total++;
      if (writes[127] !== expWrites[127]) begin
        bad++; $display("[TB] FAIL max_last_write got=%h required=%h", writes[127], expWrites[127]);
      end
    end
  endtask

  task automatic test_random_frames();
    int n;
    for (int f = 0; f < 25; f++) begin
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(129, 255) : $urandom_range(0, 8);
      buildFrame(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      modelStream();
      writes.delete();
      sendStream();
      total++;
      if ({done, error, cpuHold, wordsLoaded} !== {expDone, expErr, !expDone, expWl}) begin
        bad++; $display("[TB] FAIL rand%0d_status got done=%b err=%b hold=%b wl=%0d required %b/%b/%b/%0d",
                        f, done, error, cpuHold, wordsLoaded, expDone, expErr, !expDone, expWl);
      end
      total++;
      if (writes.size() != expWrites.size()) begin
        bad++; $display("[TB] FAIL rand%0d_count got=%0d required=%0d", f, writes.size(), expWrites.size());
      end else begin
        foreach (expWrites[i]) begin
          total++;
          if (writes[i] !== expWrites[i]) begin
            bad++; $display("[TB] FAIL rand%0d_write%0d got=%h required=%h", f, i, writes[i], expWrites[i]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    byteIn = 8'h00;
    byteValid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_basic_frame();
    test_bad_checksum();
    test_zero_frame();
    test_oversize();
    test_reset_mid_frame();
    test_idle_wait();
    test_max_frame();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/n1_prog_loader.md
Name: n1_prog_loader

Overview:
Upstream program-load stage for the n1 CPU core. Receives a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words, high byte first. Writes the words into the CPU's instruction RAM through a one-word write port. Holds the CPU in reset until a frame with a matching checksum has been fully loaded.

Parameters:
RAM_WORDS, 128, depth of instruction RAM in 16-bit words
ADDR_BITS, $clog2(RAM_WORDS), width of mem_addr
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 1024, inter-byte timeout (only used when LOADER_TIMEOUT_EN is defined)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
byte_in  in  8  incoming stream byte
byte_valid  in  1  byte_in is valid this cycle
byte_ready  out  1  loader accepts byte this cycle; transfer happens when valid && ready
mem_we  out  1  single-cycle RAM write strobe
mem_addr  out  ADDR_BITS  RAM write address
mem_wdata  out  16  RAM write data
cpu_hold  out  1  high = CPU must stay in reset (drives the CPU's rst_n low)
done  out  1  frame loaded, checksum matched
error  out  1  frame rejected
words_loaded  out  8  number of words written in the current or last frame

Behaviour:
- Reset (async, rst=1): state=IDLE. Output reset values:
  - byte_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, done=0, error=0, words_loaded=0.
  - Internal count=0, checksum=0.
- Frame format: SYNC_BYTE, N (word count), 2N payload bytes (each word hi then lo), then CHK. CHK = XOR of N and all payload bytes.
- States: IDLE, COUNT, HI, LO, WRITE, CHK, DONE, ERR.
- IDLE:
  - Accepted byte == SYNC_BYTE -> COUNT. Clear checksum and words_loaded; set cpu_hold=1.
  - Any other byte is consumed and discarded; state is unchanged.
- COUNT:
  - Accepted byte N: checksum ^= N.
  - N > RAM_WORDS -> ERR.
  - N == 0 -> CHK.
  - Otherwise -> HI.
- HI:
  - Accepted byte stored as wdata[15:8]; checksum ^= byte.
  - -> LO.
- LO:
  - Accepted byte stored as wdata[7:0]; checksum ^= byte.
  - -> WRITE.
- WRITE (exactly 1 cycle):
  - byte_ready=0, mem_we=1, mem_addr = words_loaded[ADDR_BITS-1:0].
  - mem_wdata is stable from this cycle until the next LO acceptance.
  - words_loaded increments at the end of the cycle.
  - If the incremented value == N -> CHK, else -> HI.
  - The write strobe therefore appears 1 cycle after the lo-byte handshake.
- CHK:
  - Accepted byte == checksum -> DONE.
  - Otherwise -> ERR.
- DONE: done=1, cpu_hold=0.
- ERR: error=1, cpu_hold=1.
- Leaving DONE/ERR:
  - Both are sticky. Non-sync bytes are consumed and ignored.
  - An accepted SYNC_BYTE clears done/error, sets cpu_hold=1 and -> COUNT, i.e. a reload.
  - cpu_hold rises in the same cycle the sync byte is accepted (registered output).
- byte_ready is 1 in every state except WRITE.
- words_loaded saturates implicitly, because N <= RAM_WORDS <= 255.
- SYNC_BYTE inside the payload, count or checksum position is treated as data, never as a restart.
- mem_we is never asserted outside WRITE. RAM contents written before an ERR are not rolled back; cpu_hold stays high.
- Reset asserted mid-frame aborts immediately to IDLE with all outputs at reset values. No further writes occur.

Optional Feature:
LOADER_TIMEOUT_EN
- When defined:
  - A 16-bit idle counter runs in COUNT, HI, LO and CHK.
  - It clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1 without a byte, the state goes to ERR (error=1) on the next edge.
  - The counter is held at 0 in IDLE, WRITE, DONE and ERR.
- When undefined: no counter logic; the loader waits indefinitely for each byte.

Test Plan:
- Reset release, then stream A5, 02, 10, 2A, 40, 2A, CHK=0x02^0x10^0x2A^0x40^0x2A=0x52 -> two writes: addr0=0x102A, addr1=0x402A. Each mem_we comes 1 cycle after its lo byte; then done=1, cpu_hold=0, words_loaded=2.
- Same frame with CHK=0x53 -> error=1, done=0, cpu_hold=1. Both RAM writes still occurred.
- Stream 00, FF, A5, 00, 00 -> leading junk discarded, zero writes, done=1. A following A5 clears done and raises cpu_hold in the same cycle.
- A5, 0x81 (129 > 128) -> error=1 immediately, no mem_we. A subsequent valid frame A5,01,12,34,CHK=0x27 -> done=1, addr0=0x1234.
- Assert rst for 1 cycle after the HI byte of word 0 -> outputs return to reset values. No mem_we for the interrupted word; words_loaded=0.
- With LOADER_TIMEOUT_EN, send A5,01,12 and then idle 1024 cycles -> error=1. Without the macro, the same idle leaves state in LO, error=0, and sending 34,27 completes with done=1.
